// File: rtl/led_pattern_sequencer_if.sv
// Valid/ready pattern channel between the sequencer and the LED serial driver.
interface led_pattern_sequencer_if;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/led_pattern_sequencer.sv
// 4-bit LED pattern generator: debounced mode button, programmable step rate,
// patterns offered over a valid/ready handshake that never withdraws an offer.
module led_pattern_sequencer #(
  parameter int TICK_DIV        = 500000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                     CLOCK_5,
  input  logic                     reset,
  input  logic                     btn_mode,
  input  logic                     run,
  led_pattern_sequencer_if.master  drv,
  output logic [1:0]               mode,
  output logic [7:0]               step_count
);
  typedef enum logic [1:0] {IDLE, OFFER, WAIT} state_t;

  state_t      state, state_n;
  logic        sync1, sync2, db_level, db_prev, press;
  logic [19:0] db_cnt;
  logic [23:0] tick, tick_n;
  logic [3:0]  data_q, data_n, pattern, pattern_n, adv;
  logic        dir_down, dir_n, reload, reload_n;
  logic [1:0]  mode_n;
  logic [7:0]  step_n;

  function automatic logic [3:0] seed(input logic [1:0] m);
    return (m == 2'd1 || m == 2'd2) ? 4'b0001 : 4'b0000;
  endfunction

  // Button: 2-FF synchronizer, then require DEBOUNCE_CYCLES stable cycles.
  always_ff @(posedge CLOCK_5 or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= btn_mode;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 != db_level) begin
        if (db_cnt == 20'(DEBOUNCE_CYCLES - 1)) begin
          db_level <= sync2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 20'd1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = db_level & ~db_prev;

  always_comb begin
    adv = pattern;
    case (mode)
      2'd0: adv = pattern + 4'd1;
      2'd1: adv = {pattern[2:0], pattern[3]};
      2'd2: adv = dir_down ? (pattern >> 1) : (pattern << 1);
      default: adv = ~pattern;
    endcase
  end

  always_comb begin
    state_n   = state;
    data_n    = data_q;
    pattern_n = pattern;
    dir_n     = dir_down;
    tick_n    = tick;
    reload_n  = reload;
    step_n    = step_count;
    mode_n    = mode;
    if (press) begin
      mode_n    = mode + 2'd1;
      pattern_n = seed(mode + 2'd1);
      dir_n     = 1'b0;
      tick_n    = '0;
      step_n    = '0;
      reload_n  = 1'b1;
    end
    case (state)
      IDLE: begin
        // Pattern already holds the seed here, so no reload is needed.
        reload_n = 1'b0;
        if (run) begin
          state_n = OFFER;
          data_n  = pattern_n;
        end
      end
      OFFER: begin
        if (drv.out_ready) begin
          tick_n = '0;
          if (reload || press) begin
            // The accepted pattern belonged to the old mode; WAIT sees reload
            // and offers the seed one cycle later with valid low in between.
            step_n   = '0;
            reload_n = 1'b1;
            state_n  = WAIT;
          end else begin
            step_n  = step_count + 8'd1;
            state_n = run ? WAIT : IDLE;
          end
        end
      end
      WAIT: begin
        if (reload) begin
          state_n  = OFFER;
          data_n   = pattern_n;
          reload_n = 1'b0;
          tick_n   = '0;
        end else if (!run) begin
          state_n = IDLE;
          tick_n  = '0;
        end else if (press) begin
          state_n  = OFFER;
          data_n   = pattern_n;
          reload_n = 1'b0;
        end else if (tick == 24'(TICK_DIV - 1)) begin
          state_n   = OFFER;
          pattern_n = adv;
          data_n    = adv;
          tick_n    = '0;
          if (mode == 2'd2 && adv == 4'b1000) dir_n = 1'b1;
          if (mode == 2'd2 && adv == 4'b0001) dir_n = 1'b0;
        end else begin
          tick_n = tick + 24'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_5 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      data_q     <= '0;
      pattern    <= '0;
      dir_down   <= 1'b0;
      tick       <= '0;
      reload     <= 1'b0;
      step_count <= '0;
      mode       <= '0;
    end else begin
      state      <= state_n;
      data_q     <= data_n;
      pattern    <= pattern_n;
      dir_down   <= dir_n;
      tick       <= tick_n;
      reload     <= reload_n;
      step_count <= step_n;
      mode       <= mode_n;
    end
  end

  assign drv.out_valid = (state == OFFER);
  assign drv.out_data  = data_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: expected transfers are queued by the stimulus and popped
// by a monitor on every accepted handshake.
module tb_led_pattern_sequencer;
  logic       clk = 1'b0;
  logic       reset, btn, run;
  logic [1:0] mode;
  logic [7:0] step_count;
  int         n_total = 0, n_pass = 0, cyc = 0;
  int         t_last = 0, t_prev = 0;

  typedef struct packed {logic [3:0] data; logic [7:0] step;} exp_t;
  exp_t q[$];

  led_pattern_sequencer_if bus();

  led_pattern_sequencer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .CLOCK_5(clk), .reset(reset), .btn_mode(btn), .run(run),
    .drv(bus.master), .mode(mode), .step_count(step_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int d, input int s);
    q.push_back({4'(d), 8'(s)});
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_xfer: got data %0d with empty scoreboard", bus.out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("xfer_data", int'(bus.out_data), int'(e.data));
        chk("xfer_step", int'(step_count), int'(e.step));
      end
      t_prev = t_last;
      t_last = cyc;
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_valid", int'(bus.out_valid), 1);
  endtask

  task automatic tap();
    btn = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1; btn = 1'b0; run = 1'b0; bus.out_ready = 1'b0;
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_step", int'(step_count), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Count mode through 257 transfers: 0..15 repeating, step wraps to 0.
    for (int k = 0; k <= 256; k++) push(k % 16, k % 256);
    @(posedge clk); #1 run = 1'b1; bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;
    chk("offer_spacing", t_last - t_prev, 5);

    // Backpressure: offer 0001 held for 20 cycles, then exactly one transfer.
    wait_valid();
    chk("bp_data0", int'(bus.out_data), 1);
    repeat (20) begin
      @(negedge clk);
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_data", int'(bus.out_data), 1);
    end
    push(1, 1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    chk("bp_step", int'(step_count), 2);
    chk("bp_valid_drop", int'(bus.out_valid), 0);
    chk("bp_sb_empty", q.size(), 0);

    // Async reset in the middle of offering 0101.
    push(2, 2); push(3, 3); push(4, 4);
    bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;
    wait_valid();
    chk("pre_rst_data", int'(bus.out_data), 5);
    @(negedge clk); #2 reset = 1'b1; run = 1'b0;
    #1;
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_data", int'(bus.out_data), 0);
    chk("arst_mode", int'(mode), 0);
    chk("arst_step", int'(step_count), 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_after_rst", int'(bus.out_valid), 0);

    // Press while offering 0110 in mode 0: pending transfer, gap, then seed 0001.
    for (int k = 0; k <= 5; k++) push(k, k);
    run = 1'b1; bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;
    wait_valid();
    chk("hold_data", int'(bus.out_data), 6);
    btn = 1'b1;
    n = 0;
    while (mode != 2'd1 && n < 30) begin @(posedge clk); #1; n++; end
    chk("press_mode", int'(mode), 1);
    chk("press_keeps_data", int'(bus.out_data), 6);
    chk("press_keeps_valid", int'(bus.out_valid), 1);
    push(6, 0); push(1, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("reload_gap", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("reload_valid", int'(bus.out_valid), 1);
    chk("reload_seed", int'(bus.out_data), 1);
    chk("reload_step", int'(step_count), 0);
    drain();
    bus.out_ready = 1'b0;
    btn = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("release_no_effect", int'(mode), 1);

    // Ping-pong: pending walking-one 0010 first, then no repeated endpoints.
    wait_valid();
    tap();
    chk("mode2", int'(mode), 2);
    push(2, 0); push(1, 0); push(2, 1); push(4, 2); push(8, 3);
    push(4, 4); push(2, 5); push(1, 6); push(2, 7);
    bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;

    // Bouncing button: no change while bouncing, one increment 5+1 edges after stable.
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      repeat (2) @(posedge clk);
      #1;
    end
    chk("bounce_no_change", int'(mode), 2);
    btn = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("db_not_yet", int'(mode), 2);
    @(posedge clk); #1 chk("db_mode3", int'(mode), 3);
    btn = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Blink after the pending ping-pong 0100.
    push(4, 0); push(0, 0); push(15, 1); push(0, 2);
    bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;

    // Fourth press wraps back to mode 0.
    tap();
    chk("mode_wrap", int'(mode), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
